wb_stage_ctrl: RTL and testbench

Parametrised write-back stage for the MIPS pipeline. It replaces the bare WB decoder with a registered MEM/WB stage that does several things:
- decodes the op/funct fields;
- waits for variable-latency load data, using a valid strobe and backpressure;
- aligns and sign-extends sub-word loads;
- drives the register-file write port.

It sits between the MEM stage and the register file.

---
 rtl/wb_pkg.sv | 32 +++
 rtl/wb_decode.sv | 43 ++++
 rtl/wb_stage_ctrl.sv | 140 ++++++++++++++
 tb/tb_wb_stage_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the MEM/WB stage: opcodes, write-back source/destination,
// load sizes, FSM states and the decoded-instruction struct.
package wb_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_MEM = 2'd1, SRC_LINK = 2'd2} wbSrcT;
  typedef enum logic [1:0] {DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2} wbDstT;
  typedef enum logic [1:0] {LS_W = 2'd0, LS_H = 2'd1, LS_B = 2'd2} loadSizeT;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_EXEC = 2'd1, ST_WAIT_LOAD = 2'd2} stateT;

  typedef struct packed {
    logic     we;
    wbSrcT    src;
    wbDstT    dst;
    logic     isLoad;
    loadSizeT loadSize;
  } decT;

endpackage

// File: rtl/wb_decode.sv
// Combinational op/funct decoder for the write-back stage.
module wb_decode
  import wb_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output decT        dec
);

  always_comb begin
    dec = '{we: 1'b0, src: SRC_ALU, dst: DST_RT, isLoad: 1'b0, loadSize: LS_W};
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_SLL: begin
            dec.we  = 1'b1;
            dec.dst = DST_RD;
          end
          FN_JALR: begin
            dec.we  = 1'b1;
            dec.src = SRC_LINK;
            dec.dst = DST_RD;
          end
          default: ;  // jr and unknown functs retire without a write
        endcase
      end
      OP_ORI, OP_LUI: dec.we = 1'b1;
      OP_LW, OP_LH, OP_LB: begin
        dec.we       = 1'b1;
        dec.src      = SRC_MEM;
        dec.isLoad   = 1'b1;
        dec.loadSize = (op == OP_LW) ? LS_W : (op == OP_LH) ? LS_H : LS_B;
      end
      OP_JAL: begin
        dec.we  = 1'b1;
        dec.src = SRC_LINK;
        dec.dst = DST_RA;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage_ctrl.sv
// Registered MEM/WB stage: holds one instruction, waits for load data, drives the RF write port.
// Optional perf counters (retire_cnt/stall_cnt) are built when WB_PERF_CNT_EN is defined.
module wb_stage_ctrl
  import wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int LINK_OFFSET = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              retire,
  output logic [31:0]       retire_cnt,
  output logic [31:0]       stall_cnt
);

  stateT             state;
  decT               dec;
  logic              capture;
  logic [REG_AW-1:0] dstAddr;

  logic              hWe;
  wbSrcT             hSrc;
  loadSizeT          hSize;
  logic [REG_AW-1:0] hWaddr;
  logic [DATA_W-1:0] hAlu;
  logic [DATA_W-1:0] hLink;

  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [DATA_W-1:0] loadData;

  wb_decode uDecode (.op(op), .funct(funct), .dec(dec));

  assign in_ready = (state != ST_WAIT_LOAD) | mem_rvalid;
  assign capture  = in_valid & in_ready & ~flush;

  always_comb begin
    case (dec.dst)
      DST_RD:  dstAddr = rd;
      DST_RA:  dstAddr = REG_AW'(31);
      default: dstAddr = rt;
    endcase
  end

  // Zero-register suppression is resolved at capture so outputs stay a pure function of held state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_EMPTY;
      hWe    <= 1'b0;
      hSrc   <= SRC_ALU;
      hSize  <= LS_W;
      hWaddr <= '0;
      hAlu   <= '0;
      hLink  <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else if (capture) begin
      state  <= dec.isLoad ? ST_WAIT_LOAD : ST_EXEC;
      hWe    <= dec.we & (dstAddr != '0);
      hSrc   <= dec.src;
      hSize  <= dec.loadSize;
      hWaddr <= dstAddr;
      hAlu   <= alu_result;
      hLink  <= pc + DATA_W'(LINK_OFFSET);
    end else if (state == ST_EXEC || (state == ST_WAIT_LOAD && mem_rvalid)) begin
      state <= ST_EMPTY;
    end
  end

  // Little-endian lane select from the captured byte offset.
  always_comb begin
    case (hAlu[1:0])
      2'd0:    byteSel = mem_rdata[7:0];
      2'd1:    byteSel = mem_rdata[15:8];
      2'd2:    byteSel = mem_rdata[23:16];
      default: byteSel = mem_rdata[31:24];
    endcase
    halfSel = hAlu[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (hSize)
      LS_H:    loadData = {{(DATA_W-16){halfSel[15]}}, halfSel};
      LS_B:    loadData = {{(DATA_W-8){byteSel[7]}}, byteSel};
      default: loadData = mem_rdata;
    endcase
  end

  always_comb begin
    case (hSrc)
      SRC_MEM:  reg_wdata = loadData;
      SRC_LINK: reg_wdata = hLink;
      default:  reg_wdata = hAlu;
    endcase
    case (state)
      ST_EXEC: begin
        reg_we = hWe;
        retire = 1'b1;
      end
      ST_WAIT_LOAD: begin
        reg_we = hWe & mem_rvalid & ~flush;
        retire = mem_rvalid & ~flush;
      end
      default: begin
        reg_we = 1'b0;
        retire = 1'b0;
      end
    endcase
  end

  assign reg_waddr = hWaddr;

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (retire) retire_cnt <= retire_cnt + 32'd1;
      if (state == ST_WAIT_LOAD && !mem_rvalid) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign retire_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Directed-vector bench for wb_stage_ctrl; expected values are hand-computed constants.
module tb_wb_stage_ctrl;

`ifdef WB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush;
  logic [5:0]  op, funct;
  logic [4:0]  rt, rd;
  logic [31:0] pc, alu_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        retire;
  logic [31:0] retire_cnt, stall_cnt;

  int vectors = 0;
  int miss    = 0;

  wb_stage_ctrl #(.DATA_W(32), .REG_AW(5), .LINK_OFFSET(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .op(op), .funct(funct), .rt(rt), .rd(rd), .pc(pc), .alu_result(alu_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .retire(retire), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic [4:0] t,
                       input logic [4:0] d, input logic [31:0] p, input logic [31:0] a);
    in_valid = 1'b1; op = o; funct = f; rt = t; rd = d; pc = p; alu_result = a;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; op = '0; funct = '0; rt = '0; rd = '0;
    pc = '0; alu_result = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    chk("rst_we",     32'(reg_we), 32'd0);
    chk("rst_waddr",  32'(reg_waddr), 32'd0);
    chk("rst_wdata",  reg_wdata, 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_ready",  32'(in_ready), 32'd1);
    chk("rst_rcnt",   retire_cnt, 32'd0);
    chk("rst_scnt",   stall_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // addu rd=5
    issue(6'b000000, 6'b100001, 5'd2, 5'd5, 32'h0, 32'h12345678);
    cyc(); in_valid = 1'b0; #1;
    chk("addu_we",     32'(reg_we), 32'd1);
    chk("addu_waddr",  32'(reg_waddr), 32'd5);
    chk("addu_wdata",  reg_wdata, 32'h12345678);
    chk("addu_retire", 32'(retire), 32'd1);
    cyc(); #1;
    chk("addu_hold1",  32'(retire), 32'd0);

    // lb off=3 rt=8, data three cycles later
    issue(6'b100000, 6'b000000, 5'd8, 5'd0, 32'h0, 32'h00000003);
    cyc(); in_valid = 1'b0; #1;
    chk("lb_ready1", 32'(in_ready), 32'd0);
    chk("lb_we1",    32'(reg_we), 32'd0);
    cyc(); #1;
    chk("lb_ready2", 32'(in_ready), 32'd0);
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h80FFFFFF; #1;
    chk("lb_we",     32'(reg_we), 32'd1);
    chk("lb_waddr",  32'(reg_waddr), 32'd8);
    chk("lb_wdata",  reg_wdata, 32'hFFFFFF80);
    chk("lb_ready3", 32'(in_ready), 32'd1);
    chk("lb_scnt",   stall_cnt, PERF ? 32'd2 : 32'd0);
    cyc(); mem_rvalid = 1'b0;

    // jal
    issue(6'b000011, 6'b000000, 5'd0, 5'd0, 32'h00003000, 32'h0);
    cyc(); in_valid = 1'b0; #1;
    chk("jal_waddr", 32'(reg_waddr), 32'd31);
    chk("jal_wdata", reg_wdata, 32'h00003008);
    chk("jal_we",    32'(reg_we), 32'd1);

    // jalr rd=4
    issue(6'b000000, 6'b001001, 5'd0, 5'd4, 32'h00000100, 32'h0);
    cyc(); in_valid = 1'b0; #1;
    chk("jalr_waddr", 32'(reg_waddr), 32'd4);
    chk("jalr_wdata", reg_wdata, 32'h00000108);

    // ori rt=0: retires, no write
    issue(6'b001101, 6'b000000, 5'd0, 5'd0, 32'h0, 32'hABCD);
    cyc(); in_valid = 1'b0; #1;
    chk("ori0_we",     32'(reg_we), 32'd0);
    chk("ori0_retire", 32'(retire), 32'd1);

    // lh off=2, data next cycle
    issue(6'b100001, 6'b000000, 5'd7, 5'd0, 32'h0, 32'h00000002);
    cyc(); in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80011234; #1;
    chk("lh_we",    32'(reg_we), 32'd1);
    chk("lh_waddr", 32'(reg_waddr), 32'd7);
    chk("lh_wdata", reg_wdata, 32'hFFFF8001);
    cyc(); mem_rvalid = 1'b0;

    // lw killed by flush coinciding with rvalid
    issue(6'b100011, 6'b000000, 5'd9, 5'd0, 32'h0, 32'h0);
    cyc(); in_valid = 1'b0; mem_rvalid = 1'b1; flush = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    chk("fl_we",     32'(reg_we), 32'd0);
    chk("fl_retire", 32'(retire), 32'd0);
    cyc(); flush = 1'b0; #1;
    chk("fl_empty_retire", 32'(retire), 32'd0);
    chk("fl_empty_we",     32'(reg_we), 32'd0);
    chk("fl_rcnt",         retire_cnt, PERF ? 32'd6 : 32'd0);
    mem_rvalid = 1'b0;

    // alternating lw / addu at one per cycle
    issue(6'b100011, 6'b000000, 5'd10, 5'd0, 32'h0, 32'h0);
    cyc(); issue(6'b000000, 6'b100001, 5'd0, 5'd11, 32'h0, 32'h22222222);
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111; #1;
    chk("b2b_ready", 32'(in_ready), 32'd1);
    chk("b2b_w1a",   32'(reg_waddr), 32'd10);
    chk("b2b_w1d",   reg_wdata, 32'h11111111);
    chk("b2b_w1e",   32'(reg_we), 32'd1);
    cyc(); issue(6'b100011, 6'b000000, 5'd12, 5'd0, 32'h0, 32'h0); mem_rvalid = 1'b0; #1;
    chk("b2b_w2a",   32'(reg_waddr), 32'd11);
    chk("b2b_w2d",   reg_wdata, 32'h22222222);
    chk("b2b_w2e",   32'(reg_we), 32'd1);
    cyc(); issue(6'b000000, 6'b100001, 5'd0, 5'd13, 32'h0, 32'h44444444);
    mem_rvalid = 1'b1; mem_rdata = 32'h33333333; #1;
    chk("b2b_w3a",   32'(reg_waddr), 32'd12);
    chk("b2b_w3d",   reg_wdata, 32'h33333333);
    cyc(); in_valid = 1'b0; mem_rvalid = 1'b0; #1;
    chk("b2b_w4a",   32'(reg_waddr), 32'd13);
    chk("b2b_w4d",   reg_wdata, 32'h44444444);
    chk("b2b_w4e",   32'(reg_we), 32'd1);
    cyc(); #1;
    chk("b2b_rcnt",  retire_cnt, PERF ? 32'd10 : 32'd0);
    chk("b2b_scnt",  stall_cnt, PERF ? 32'd2 : 32'd0);

    // asynchronous reset while a load waits
    issue(6'b100011, 6'b000000, 5'd14, 5'd0, 32'h0, 32'h0);
    cyc(); in_valid = 1'b0; #1;
    chk("mid_ready0", 32'(in_ready), 32'd0);
    reset = 1'b0; #1;
    chk("mid_ready1", 32'(in_ready), 32'd1);
    chk("mid_rcnt",   retire_cnt, 32'd0);
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55555555; #1;
    chk("mid_we",     32'(reg_we), 32'd0);
    chk("mid_retire", 32'(retire), 32'd0);
    cyc(); mem_rvalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
